// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with 3-sample majority vote, configurable framing,
// and a one-word output register with parity/framing/overrun/break flags.
module uart_rx_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int OVS       = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 OVS_CE,
    input  logic                 RXD,
    input  logic                 RX_READY,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 PAR_ERR,
    output logic                 FRM_ERR,
    output logic                 OVR_ERR,
    output logic                 BREAK,
    output logic                 BUSY
);
    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T_S0  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVS / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);
    localparam logic [3:0]    LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WEND} state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_sync;
    logic [TW-1:0]        r_tick, w_tick;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0, r_s1, r_perr, r_frm, r_brk;
    logic                 w_rxs, w_run, w_start, w_dec, w_end, w_maj;
    logic                 w_frm, w_brk, w_deliver, w_load, w_hs;

    assign w_rxs = r_sync[1];
    assign BUSY  = r_state != S_IDLE;

    // w_tick is the index of the tick being processed on this OVS_CE
    always_comb begin
        w_tick      = (r_tick == T_END) ? '0 : r_tick + 1'b1;
        w_run       = OVS_CE && BUSY && r_state != S_WEND;
        w_start     = OVS_CE && r_state == S_IDLE && !w_rxs;
        w_dec       = w_run && w_tick == T_DEC;
        w_end       = w_run && w_tick == T_END;
        w_maj       = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
        w_frm       = r_frm | !w_maj;
        w_brk       = (r_bit == '0) ? (r_shift == '0 && !w_maj) : r_brk;
        w_deliver   = w_dec && r_state == S_STOP && r_bit == LAST_S;
        w_load      = w_deliver && (!RX_VALID || RX_READY);
        w_hs        = RX_VALID && RX_READY;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_start ? S_START : S_IDLE;
            S_START: w_state_nxt = (w_dec && w_maj) ? S_IDLE : (w_end ? S_DATA : S_START);
            S_DATA:  w_state_nxt = (w_end && r_bit == LAST_D) ? ((PARITY != 0) ? S_PAR : S_STOP) : S_DATA;
            S_PAR:   w_state_nxt = w_end ? S_STOP : S_PAR;
            S_STOP:  w_state_nxt = w_deliver ? (w_frm ? S_WEND : S_IDLE) : S_STOP;
            S_WEND:  w_state_nxt = w_rxs ? S_IDLE : S_WEND;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync   <= 2'b11;
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_s0     <= 1'b0;
            r_s1     <= 1'b0;
            r_perr   <= 1'b0;
            r_frm    <= 1'b0;
            r_brk    <= 1'b0;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
            PAR_ERR  <= 1'b0;
            FRM_ERR  <= 1'b0;
            OVR_ERR  <= 1'b0;
            BREAK    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], RXD};
            if (w_start) begin
                r_tick  <= '0;
                r_bit   <= '0;
                r_shift <= '0;
                r_perr  <= 1'b0;
                r_frm   <= 1'b0;
                r_brk   <= 1'b0;
            end else if (w_run) begin
                r_tick <= w_tick;
                if (w_tick == T_S0) r_s0 <= w_rxs;
                if (w_tick == T_S1) r_s1 <= w_rxs;
                if (w_dec && r_state == S_DATA) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                if (w_dec && r_state == S_PAR) r_perr <= (PARITY == 2) ^ (^r_shift) ^ w_maj;
                if (w_dec && r_state == S_STOP) begin
                    r_frm <= w_frm;
                    r_brk <= w_brk;
                end
                if (w_end && (r_state == S_DATA || r_state == S_STOP))
                    r_bit <= (r_state == S_DATA && r_bit == LAST_D) ? '0 : r_bit + 1'b1;
            end
            if (w_load) begin
                RX_DATA <= r_shift;
                PAR_ERR <= r_perr;
                FRM_ERR <= w_frm;
            end
            RX_VALID <= w_load | (RX_VALID & ~RX_READY);
            // a drop in the same cycle as a handshake still reports the overrun
            OVR_ERR  <= (w_deliver & ~w_load) | (OVR_ERR & ~w_hs);
            BREAK    <= (w_deliver & w_brk) | (BREAK & ~(r_state == S_WEND && w_rxs));
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives serial frames into two receiver configurations and checks the
// delivered words and flags against values computed from the frame contents.
module tb_uart_rx_param;
    localparam int OVS = 16;

    logic CLK = 1'b0, RST = 1'b1, OVS_CE = 1'b0, RXD = 1'b1, RXD2 = 1'b1, RX_READY = 1'b0;
    logic [7:0] RX_DATA;
    logic [6:0] RX_DATA2;
    logic RX_VALID, PAR_ERR, FRM_ERR, OVR_ERR, BREAK, BUSY;
    logic RX_VALID2, PAR_ERR2, FRM_ERR2, OVR_ERR2, BREAK2, BUSY2;
    int checks = 0, errors = 0, ce_div = 1;

    uart_rx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVS(OVS)) u_dut (
        .CLK(CLK), .RST(RST), .OVS_CE(OVS_CE), .RXD(RXD), .RX_READY(RX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR),
        .OVR_ERR(OVR_ERR), .BREAK(BREAK), .BUSY(BUSY));

    uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVS(OVS)) u_dut2 (
        .CLK(CLK), .RST(RST), .OVS_CE(OVS_CE), .RXD(RXD2), .RX_READY(RX_READY),
        .RX_DATA(RX_DATA2), .RX_VALID(RX_VALID2), .PAR_ERR(PAR_ERR2), .FRM_ERR(FRM_ERR2),
        .OVR_ERR(OVR_ERR2), .BREAK(BREAK2), .BUSY(BUSY2));

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles");
        $fatal(1);
    end

    task automatic tick();
        for (int k = 1; k < ce_div; k++) begin
            OVS_CE = 1'b0;
            @(negedge CLK);
        end
        OVS_CE = 1'b1;
        @(negedge CLK);
    endtask

    // frame bits in line order: start, data LSB first, optional parity, stop bits
    function automatic logic [15:0] mk_frame(input logic [8:0] d, input int dbits, input int np,
                                             input logic pb, input int ns, input logic s0, input logic s1);
        logic [15:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        n = 1;
        for (int b = 0; b < dbits; b++) begin
            f[n] = d[b];
            n++;
        end
        if (np != 0) begin
            f[n] = pb;
            n++;
        end
        f[n] = s0;
        if (ns == 2) f[n+1] = s1;
        return f;
    endfunction

    task automatic send_frame(input bit sel, input logic [15:0] fb, input int nb, input int glitch,
                              input int ready_at, input int rst_at, input int idle);
        for (int i = 0; i < nb * OVS; i++) begin
            logic v;
            if (i == rst_at) begin
                RXD = 1'b1;
                OVS_CE = 1'b0;
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                break;
            end
            v = fb[i / OVS] ^ (i == glitch);
            if (sel) RXD2 = v; else RXD = v;
            if (ready_at >= 0) RX_READY = (i == ready_at);
            tick();
        end
        if (ready_at >= 0) RX_READY = 1'b0;
        if (idle > 0) begin
            RXD = 1'b1;
            RXD2 = 1'b1;
            repeat (idle) tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid_held: got %b want 0", RX_VALID); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", RX_DATA); end
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", RX_VALID); end
        checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL rst_par: got %b want 0", PAR_ERR); end
        checks++; if (FRM_ERR !== 1'b0) begin errors++; $display("FAIL rst_frm: got %b want 0", FRM_ERR); end
        checks++; if (OVR_ERR !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", OVR_ERR); end
        checks++; if (BREAK !== 1'b0) begin errors++; $display("FAIL rst_break: got %b want 0", BREAK); end
        checks++; if (BUSY !== 1'b0 || BUSY2 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b/%b want 0/0", BUSY, BUSY2); end
    endtask

    task automatic test_basic();
        send_frame(0, mk_frame(9'h0A5, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, -1, -1, -1, OVS);
        checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", RX_VALID); end
        checks++; if (RX_DATA !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", RX_DATA); end
        checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL basic_par: got %b want 0", PAR_ERR); end
        checks++; if (FRM_ERR !== 1'b0) begin errors++; $display("FAIL basic_frm: got %b want 0", FRM_ERR); end
        OVS_CE = 1'b0;
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL basic_hs_valid: got %b want 0", RX_VALID); end
        checks++; if (RX_DATA !== 8'hA5) begin errors++; $display("FAIL basic_hs_data: got %h want a5", RX_DATA); end
    endtask

    task automatic test_fmt2();
        send_frame(1, mk_frame(9'h03C, 7, 1, 1'b0, 2, 1'b1, 1'b1), 11, -1, -1, -1, 0);
        checks++; if (RX_VALID2 !== 1'b1) begin errors++; $display("FAIL fmt2_valid: got %b want 1", RX_VALID2); end
        checks++; if (RX_DATA2 !== 7'h3C) begin errors++; $display("FAIL fmt2_data: got %h want 3c", RX_DATA2); end
        checks++; if (PAR_ERR2 !== 1'b1) begin errors++; $display("FAIL fmt2_par: got %b want 1", PAR_ERR2); end
        checks++; if (FRM_ERR2 !== 1'b0) begin errors++; $display("FAIL fmt2_frm: got %b want 0", FRM_ERR2); end
        checks++; if (BUSY2 !== 1'b0) begin errors++; $display("FAIL fmt2_idle: got %b want 0", BUSY2); end
        OVS_CE = 1'b0;
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
        repeat (OVS) tick();
        send_frame(1, mk_frame(9'h03C, 7, 1, 1'b1, 2, 1'b1, 1'b0), 11, -1, -1, -1, 0);
        checks++; if (PAR_ERR2 !== 1'b0) begin errors++; $display("FAIL fmt2_par_ok: got %b want 0", PAR_ERR2); end
        checks++; if (FRM_ERR2 !== 1'b1) begin errors++; $display("FAIL fmt2_frm2: got %b want 1", FRM_ERR2); end
        checks++; if (BUSY2 !== 1'b1) begin errors++; $display("FAIL fmt2_wend: got %b want 1", BUSY2); end
        RXD2 = 1'b1;
        repeat (OVS) tick();
        checks++; if (BUSY2 !== 1'b0) begin errors++; $display("FAIL fmt2_wend_exit: got %b want 0", BUSY2); end
        OVS_CE = 1'b0;
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
    endtask

    task automatic test_glitch();
        RXD = 1'b0;
        repeat (4) tick();
        RXD = 1'b1;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b want 1", BUSY); end
        repeat (7) tick();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL glitch_busy_pre: got %b want 1", BUSY); end
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b want 0", BUSY); end
        repeat (OVS) tick();
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", RX_VALID); end
        send_frame(0, mk_frame(9'h055, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, 4 * OVS + OVS / 2, -1, -1, OVS);
        checks++; if (RX_DATA !== 8'h55 || RX_VALID !== 1'b1) begin errors++; $display("FAIL vote_data: got %h/%b want 55/1", RX_DATA, RX_VALID); end
        OVS_CE = 1'b0;
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
    endtask

    task automatic test_break();
        send_frame(0, 16'h0000, 12, -1, -1, -1, 0);
        checks++; if (RX_VALID !== 1'b1 || RX_DATA !== 8'h00) begin errors++; $display("FAIL brk_data: got %h/%b want 00/1", RX_DATA, RX_VALID); end
        checks++; if (FRM_ERR !== 1'b1) begin errors++; $display("FAIL brk_frm: got %b want 1", FRM_ERR); end
        checks++; if (BREAK !== 1'b1) begin errors++; $display("FAIL brk_set: got %b want 1", BREAK); end
        RXD = 1'b1;
        OVS_CE = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (BREAK !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL brk_hold: got %b/%b want 1/1", BREAK, BUSY); end
        @(negedge CLK);
        checks++; if (BREAK !== 1'b0) begin errors++; $display("FAIL brk_clear: got %b want 0", BREAK); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL brk_idle: got %b want 0", BUSY); end
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
        repeat (OVS) tick();
    endtask

    task automatic test_overrun();
        send_frame(0, mk_frame(9'h011, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, -1, -1, -1, OVS);
        send_frame(0, mk_frame(9'h044, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, -1, -1, -1, OVS);
        checks++; if (RX_DATA !== 8'h11 || RX_VALID !== 1'b1) begin errors++; $display("FAIL ovr_held: got %h/%b want 11/1", RX_DATA, RX_VALID); end
        checks++; if (OVR_ERR !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", OVR_ERR); end
        OVS_CE = 1'b0;
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL ovr_hs_valid: got %b want 0", RX_VALID); end
        checks++; if (OVR_ERR !== 1'b0) begin errors++; $display("FAIL ovr_hs_clear: got %b want 0", OVR_ERR); end
        send_frame(0, mk_frame(9'h011, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, -1, -1, -1, OVS);
        // ready pulse lands on the final stop decision: frame latency plus the 2-CLK synchroniser
        send_frame(0, mk_frame(9'h022, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, -1, 10 * OVS + OVS / 2 + 1 + 2, -1, OVS);
        checks++; if (RX_DATA !== 8'h22 || RX_VALID !== 1'b1) begin errors++; $display("FAIL ovr_coinc_data: got %h/%b want 22/1", RX_DATA, RX_VALID); end
        checks++; if (OVR_ERR !== 1'b0) begin errors++; $display("FAIL ovr_coinc_flag: got %b want 0", OVR_ERR); end
    endtask

    task automatic test_reset_mid();
        send_frame(0, mk_frame(9'h0F0, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, -1, -1, 5 * OVS + OVS / 2, 0);
        checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", RX_DATA); end
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", RX_VALID); end
        checks++; if ({PAR_ERR, FRM_ERR, OVR_ERR, BREAK} !== 4'b0000) begin errors++; $display("FAIL rmid_flags: got %b want 0000", {PAR_ERR, FRM_ERR, OVR_ERR, BREAK}); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", BUSY); end
        repeat (OVS) tick();
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rmid_no_partial: got %b want 0", RX_VALID); end
        send_frame(0, mk_frame(9'h00F, 8, 1, 1'b0, 1, 1'b1, 1'b1), 11, -1, -1, -1, OVS);
        checks++; if (RX_DATA !== 8'h0F || RX_VALID !== 1'b1) begin errors++; $display("FAIL rmid_clean: got %h/%b want 0f/1", RX_DATA, RX_VALID); end
        checks++; if (PAR_ERR !== 1'b0 || FRM_ERR !== 1'b0) begin errors++; $display("FAIL rmid_clean_flags: got %b%b want 00", PAR_ERR, FRM_ERR); end
        OVS_CE = 1'b0;
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic pb, sb;
            d = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            ce_div = $urandom_range(1, 3);
            send_frame(0, mk_frame({1'b0, d}, 8, 1, pb, 1, sb, 1'b1), 11, -1, -1, -1, OVS);
            checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want 1", n, RX_VALID); end
            checks++; if (RX_DATA !== d) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, RX_DATA, d); end
            checks++; if (PAR_ERR !== ((^d) ^ pb)) begin errors++; $display("FAIL rnd_par[%0d]: got %b want %b", n, PAR_ERR, (^d) ^ pb); end
            checks++; if (FRM_ERR !== ~sb) begin errors++; $display("FAIL rnd_frm[%0d]: got %b want %b", n, FRM_ERR, ~sb); end
            checks++; if (OVR_ERR !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL rnd_ovr_busy[%0d]: got %b/%b want 0/0", n, OVR_ERR, BUSY); end
            OVS_CE = 1'b0;
            RX_READY = 1'b1;
            @(negedge CLK);
            RX_READY = 1'b0;
            checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rnd_hs[%0d]: got %b want 0", n, RX_VALID); end
        end
        ce_div = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fmt2();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
